// File: rtl/gpio_apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port toward a GPIO slave.
// Each transfer runs IDLE -> SETUP -> ACCESS and ends with PREADY or a wait-state timeout abort.
module gpio_apb_arbiter #(
    parameter int PDATA_SIZE = 32,
    parameter int PADDR_SIZE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 req_we_i,
    input  logic [2*PADDR_SIZE-1:0]    req_addr_i,
    input  logic [2*PDATA_SIZE-1:0]    req_wdata_i,
    input  logic [2*PDATA_SIZE/8-1:0]  req_strb_i,
    output logic [1:0]                 done_o,
    output logic [PDATA_SIZE-1:0]      rdata_o,
    output logic                       err_o,
    output logic [1:0]                 grant_o,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [PADDR_SIZE-1:0]      PADDR,
    output logic [PDATA_SIZE-1:0]      PWDATA,
    output logic [PDATA_SIZE/8-1:0]    PSTRB,
    input  logic [PDATA_SIZE-1:0]      PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         grant_q;
    logic               last_q;
    logic [CNT_W-1:0]   wait_q;

    logic               winner;
    logic               win_we;
    logic [PADDR_SIZE-1:0] win_addr;
    logic [PDATA_SIZE-1:0] win_wdata;
    logic [STRB_W-1:0]  win_strb;
    logic               timeout_hit;

    // Round-robin: on a tie the requester that did not own the bus last time wins.
    always_comb begin
        winner = 1'b0;
        unique case (req_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
        win_we    = req_we_i[winner];
        win_addr  = winner ? req_addr_i[2*PADDR_SIZE-1:PADDR_SIZE] : req_addr_i[PADDR_SIZE-1:0];
        win_wdata = winner ? req_wdata_i[2*PDATA_SIZE-1:PDATA_SIZE] : req_wdata_i[PDATA_SIZE-1:0];
        win_strb  = winner ? req_strb_i[2*STRB_W-1:STRB_W] : req_strb_i[STRB_W-1:0];
    end

    assign timeout_hit = (wait_q == CNT_W'(TIMEOUT - 1));
    assign grant_o     = grant_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        done_o  = 2'b00;
        rdata_o = '0;
        err_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                PSEL    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    done_o  = grant_q;
                    rdata_o = PWRITE ? '0 : PRDATA;
                    err_o   = PSLVERR;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    done_o  = grant_q;
                    err_o   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload is captured once at grant so the slave sees it stable even if the requester lets go.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            wait_q  <= '0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
        end else begin
            if (state_q == IDLE && |req_i) begin
                grant_q <= winner ? 2'b10 : 2'b01;
                last_q  <= winner;
                wait_q  <= '0;
                PWRITE  <= win_we;
                PADDR   <= win_addr;
                PWDATA  <= win_wdata;
                PSTRB   <= win_we ? win_strb : '0;
            end else if (state_q == ACCESS) begin
                if (state_d == IDLE) begin
                    grant_q <= 2'b00;
                end else begin
                    wait_q <= wait_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Table-driven bench for gpio_apb_arbiter: vectors push expected completions to a scoreboard
// which is popped and compared whenever done_o fires; reset corner cases are hand-written.
module tb_gpio_apb_arbiter;

    localparam int PDATA_SIZE = 32;
    localparam int PADDR_SIZE = 4;
    localparam int TIMEOUT    = 16;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_i;
    logic [1:0]  req_we_i;
    logic [7:0]  req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_strb_i;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [1:0]  grant_o;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    gpio_apb_arbiter #(
        .PDATA_SIZE(PDATA_SIZE),
        .PADDR_SIZE(PADDR_SIZE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_i      (req_i),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_strb_i (req_strb_i),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .grant_o    (grant_o),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [3:0]  addr0;
        logic [3:0]  addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        logic [3:0]  strb0;
        logic [3:0]  strb1;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        bit          drop_early;
        int          exp_owner;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[11];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic [31:0] prd, input int waits, input logic slverr,
                                input bit drop, input int owner, input logic [31:0] erd,
                                input logic eerr, input int eacc);
        vec_t v;
        v.req = req;  v.we = we;  v.addr0 = a0;  v.addr1 = a1;
        v.wdata0 = d0;  v.wdata1 = d1;  v.strb0 = s0;  v.strb1 = s1;
        v.prdata = prd;  v.waits = waits;  v.slverr = slverr;  v.drop_early = drop;
        v.exp_owner = owner;  v.exp_rdata = erd;  v.exp_err = eerr;  v.exp_acc = eacc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input int acc, input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_sb_empty: actual=done 0x%0h required=no completion", tag, done_o);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_done"},   done_o,  e.done);
        check({tag, "_rdata"},  rdata_o, e.rdata);
        check({tag, "_err"},    err_o,   e.err);
        check({tag, "_paddr"},  PADDR,   e.addr);
        check({tag, "_pwrite"}, PWRITE,  e.write);
        check({tag, "_pwdata"}, PWDATA,  e.wdata);
        check({tag, "_pstrb"},  PSTRB,   e.strb);
        check({tag, "_acc"},    acc,     e.acc);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        int   acc;
        int   cyc;
        bit   finished;
        logic w;
        @(negedge PCLK);
        req_we_i    = v.we;
        req_addr_i  = {v.addr1, v.addr0};
        req_wdata_i = {v.wdata1, v.wdata0};
        req_strb_i  = {v.strb1, v.strb0};
        req_i       = v.req;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        PRDATA      = '0;
        w       = v.we[v.exp_owner];
        e.done  = (v.exp_owner == 1) ? 2'b10 : 2'b01;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.addr  = (v.exp_owner == 1) ? v.addr1 : v.addr0;
        e.write = w;
        e.wdata = (v.exp_owner == 1) ? v.wdata1 : v.wdata0;
        e.strb  = w ? ((v.exp_owner == 1) ? v.strb1 : v.strb0) : 4'h0;
        e.acc   = v.exp_acc;
        sb_q.push_back(e);
        #1;
        check({tag, "_idle_bus"}, {PSEL, PENABLE, grant_o}, 4'h0);
        acc      = 0;
        cyc      = 0;
        finished = 1'b0;
        while (!finished && cyc < 64) begin
            @(negedge PCLK);
            cyc++;
            if (PSEL && !PENABLE) begin
                check({tag, "_setup_cycle"}, cyc, 1);
                check({tag, "_setup_grant"}, grant_o, e.done);
                if (v.drop_early) req_i = 2'b00;
            end else if (PSEL && PENABLE) begin
                acc++;
                PREADY  = (v.waits >= 0) && (acc > v.waits);
                PSLVERR = v.slverr;
                PRDATA  = v.prdata;
                #1;
                if (done_o != 2'b00) begin
                    checkOutput(acc, tag);
                    finished = 1'b1;
                    req_i    = 2'b00;
                end
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_no_done: actual=none after %0d cycles required=done", tag, cyc);
            sb_q.delete();
            req_i = 2'b00;
        end
        @(negedge PCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        #1;
        check({tag, "_back_idle"}, {PSEL, PENABLE, done_o, err_o, grant_o, rdata_o}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        PRESETn     = 1'b0;
        req_i       = 2'b00;
        req_we_i    = 2'b00;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_strb_i  = '0;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;

        vecs[0]  = mk(2'b01, 2'b01, 4'h2, 4'h0, 32'hA5A5_0001, 32'h0, 4'hF, 4'h0,
                      32'h0, 0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1);
        vecs[1]  = mk(2'b10, 2'b00, 4'h0, 4'h3, 32'h0, 32'h0, 4'h0, 4'h5,
                      32'h0000_00FF, 3, 1'b0, 1'b0, 1, 32'h0000_00FF, 1'b0, 4);
        vecs[2]  = mk(2'b11, 2'b01, 4'h1, 4'h7, 32'h1111_1111, 32'h2222_2222, 4'h3, 4'hF,
                      32'hDEAD_BEEF, 0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1);
        vecs[3]  = mk(2'b11, 2'b01, 4'h1, 4'h7, 32'h1111_1111, 32'h2222_2222, 4'h3, 4'hF,
                      32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, 1);
        vecs[4]  = mk(2'b11, 2'b10, 4'h8, 4'h9, 32'h0, 32'h3333_3333, 4'h1, 4'hC,
                      32'hCAFE_0000, 1, 1'b0, 1'b0, 0, 32'hCAFE_0000, 1'b0, 2);
        vecs[5]  = mk(2'b11, 2'b10, 4'h8, 4'h9, 32'h0, 32'h3333_3333, 4'h1, 4'hC,
                      32'hCAFE_0000, 1, 1'b0, 1'b0, 1, 32'h0, 1'b0, 2);
        vecs[6]  = mk(2'b01, 2'b01, 4'hA, 4'h0, 32'h5555_AAAA, 32'h0, 4'h6, 4'h0,
                      32'h0, 0, 1'b1, 1'b0, 0, 32'h0, 1'b1, 1);
        vecs[7]  = mk(2'b10, 2'b00, 4'h0, 4'hB, 32'h0, 32'h0, 4'h0, 4'hF,
                      32'h0000_1234, 2, 1'b1, 1'b0, 1, 32'h0000_1234, 1'b1, 3);
        vecs[8]  = mk(2'b01, 2'b00, 4'hC, 4'h0, 32'h0, 32'h0, 4'hF, 4'h0,
                      32'hFFFF_FFFF, -1, 1'b0, 1'b0, 0, 32'h0, 1'b1, TIMEOUT);
        vecs[9]  = mk(2'b10, 2'b10, 4'h0, 4'hD, 32'h0, 32'h7777_0007, 4'h0, 4'h9,
                      32'h0, 2, 1'b0, 1'b1, 1, 32'h0, 1'b0, 3);
        vecs[10] = mk(2'b01, 2'b00, 4'hE, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0,
                      32'h0BAD_F00D, TIMEOUT - 1, 1'b0, 1'b0, 0, 32'h0BAD_F00D, 1'b0, TIMEOUT);

        repeat (2) @(negedge PCLK);
        #1;
        check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, 64'h0);
        check("reset_pwdata", PWDATA, 32'h0);
        check("reset_outs", {done_o, err_o, grant_o, rdata_o}, 64'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of a stalled read: nothing may complete, bus drops at once.
        @(negedge PCLK);
        req_i      = 2'b10;
        req_we_i   = 2'b00;
        req_addr_i = {4'h5, 4'h0};
        PREADY     = 1'b0;
        acc        = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) acc++;
        end
        check("rst_reached_access", acc, 2);
        #1;
        PRESETn = 1'b0;
        #1;
        check("rst_apb_drop", {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, 64'h0);
        check("rst_outs", {done_o, err_o, grant_o, rdata_o}, 64'h0);
        req_i = 2'b00;
        @(negedge PCLK);
        #1;
        check("rst_hold_done", done_o, 2'b00);
        PRESETn = 1'b1;

        applyStimulus(mk(2'b11, 2'b11, 4'h4, 4'h6, 32'h0101_0101, 32'h0202_0202, 4'hA, 4'h5,
                         32'h0, 0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1), "post_rst_tie");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
